// File: rtl/uart_tx.sv
// UART transmitter fed by an upstream FIFO. Each frame is a start bit, the data bits LSB first,
// an optional parity bit and one or two stop bits.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY_EN != 0);
    localparam logic          ODD_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bitIdx_q, bitIdx_d;
    logic                  stopIdx_q, stopIdx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  bitEnd, finalStop, popEn;

    assign bitEnd    = (cnt_q == CNT_LAST);
    assign finalStop = (state_q == STOP) && bitEnd && (stopIdx_q == STOP_LAST);
    // The next word is popped while idle or on the final stop cycle, giving gap-free frames.
    assign popEn     = reset && !fifo_empty && ((state_q == IDLE) || finalStop);

    assign fifo_rd      = popEn;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bitEnd ? '0 : cnt_q + CW'(1);
        bitIdx_d  = bitIdx_q;
        stopIdx_d = stopIdx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        shifted   = shift_q >> 1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitIdx_d = '0;
                    tx_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d = shifted;
                    if (bitIdx_q == BIT_LAST) begin
                        stopIdx_d = 1'b0;
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + BW'(1);
                        tx_d     = shifted[0];
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    stopIdx_d = 1'b0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (stopIdx_q == STOP_LAST) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        stopIdx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (popEn) begin
            state_d  = START;
            cnt_d    = '0;
            bitIdx_d = '0;
            shift_d  = fifo_r_data;
            parity_d = (^fifo_r_data) ^ ODD_BIT;
            tx_d     = 1'b0;
        end

        // Registered done pulse: predict that the coming cycle is the final stop cycle.
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST) && (stopIdx_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            stopIdx_q <= stopIdx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (min 2).
REQ-003 Parameter PARITY_EN, default 0, 1 inserts one parity bit after data.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 Port clk  input  1  sole clock, all state on rising edge.
REQ-007 Port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-008 Port fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 Port fifo_r_data  input  DATA_WIDTH  upstream FIFO head word, valid combinationally while fifo_empty=0.
REQ-010 Port fifo_rd  output  1  pop strobe to upstream FIFO, one cycle per word.
REQ-011 Port tx  output  1  serial line, idle high.
REQ-012 Port tx_busy  output  1  high whenever a frame is in progress (state != IDLE).
REQ-013 Port tx_done_tick  output  1  one-cycle pulse on the last cycle of the last stop bit.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; tx driven from a register, no glitches.
REQ-015 Pop rule: fifo_rd = 1 combinationally in any cycle where (state==IDLE, or state==STOP on its final cycle) and fifo_empty=0; fifo_rd never asserts when fifo_empty=1.
REQ-016 On the edge ending a pop cycle, fifo_r_data is latched into an internal shift register and state moves to START; FIFO output is not sampled again for that frame.
REQ-017 Latency: pop in cycle N -> tx=0 from cycle N+1.
REQ-018 Each bit (start, data, parity, stop) holds tx for exactly CLKS_PER_BIT cycles, counted by an internal counter of width clog2(CLKS_PER_BIT), cleared on every state change.
REQ-019 START: tx=0; -> DATA.
REQ-020 DATA: tx = shift-register LSB; LSB first; after DATA_WIDTH bits -> PARITY if PARITY_EN else STOP.
REQ-021 PARITY: tx = XOR of the latched data word, inverted when PARITY_ODD=1; -> STOP.
REQ-022 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on final cycle tx_done_tick=1 and next state is START if a pop occurs (REQ-015) else IDLE.
REQ-023 Back-to-back frames carry no idle gap: stop of frame k is followed immediately by start of frame k+1.
REQ-024 Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles exactly.
REQ-025 fifo_empty changes mid-frame have no effect; fifo_r_data changes mid-frame have no effect.
REQ-026 tx_busy=0 only in IDLE; tx_done_tick never asserts outside STOP.

Reset
REQ-027 reset=0 sampled at an edge forces: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, counters and shift register=0; fifo_rd=0 during reset cycles regardless of fifo_empty.
REQ-028 Reset mid-frame aborts the frame; tx=1 from the next cycle; the popped word is discarded, not re-read.
REQ-029 First pop possible in the first cycle with reset=1 and fifo_empty=0.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, defaults otherwise)
REQ-030 Single byte 0xA5 at fifo_r_data, fifo_empty 1->0 for one pop -> fifo_rd high exactly 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); tx_done_tick at cycle 40 after pop; tx_busy falls the next cycle.
REQ-031 FIFO holding 0x00,0xFF,0x3C, fifo_empty=0 throughout -> three pops spaced exactly 40 cycles apart, no idle-high cycle between stop and next start, 3 tx_done_tick pulses.
REQ-032 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 44 cycles; PARITY_ODD=1 -> parity bit 0.
REQ-033 STOP_BITS=2, byte 0x55 -> stop high 8 cycles, frame 44 cycles, next pop on final stop cycle.
REQ-034 reset=0 for 1 cycle at cycle 15 of a frame -> tx=1, tx_busy=0 next cycle; with fifo_empty=1 no further fifo_rd; with fifo_empty=0 next pop the first cycle after reset releases.
REQ-035 fifo_empty=1 for 1000 cycles -> fifo_rd never asserts, tx constant 1, tx_busy 0.
